// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the hazard/forwarding controller.
//   fwd_sel_t  - EX-stage operand mux select (register file, W, M, M alt result)
//   rslt_src_t - result-source code carried down the pipeline with each instr
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_W     = 2'b01,
        FWD_M     = 2'b10,
        FWD_M_ALT = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RS_ALU  = 2'b00,
        RS_LOAD = 2'b01,
        RS_PC4  = 2'b10,
        RS_ALT  = 2'b11
    } rslt_src_t;

endpackage

// File: rtl/hazard_sb_regs.sv
// hazard_sb_regs: register scoreboard for long-latency (mul/div) results.
//   clk, rst       clock, synchronous active-high reset
//   set_en, set_rd accepted long-op issue and its destination register
//   clr_req,clr_rd long unit write-back this cycle and its destination
//   pending        one bit per architectural register, bit 0 always 0
//   sb_cnt         number of outstanding long ops (saturating 0..MAX_OUT)
//   sb_full        sb_cnt == MAX_OUT
// While rst is high the outputs read as an empty scoreboard, so the
// combinational stall logic never sees stale (or power-up) state.
module hazard_sb_regs #(
    parameter int NREG    = 32,
    parameter int MAX_OUT = 4,
    localparam int AW     = $clog2(NREG),
    localparam int CW     = $clog2(MAX_OUT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_rd,
    input  logic            clr_req,
    input  logic [AW-1:0]   clr_rd,
    output logic [NREG-1:0] pending,
    output logic [CW-1:0]   sb_cnt,
    output logic            sb_full
);

    logic [NREG-1:0] pending_q, pending_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            set_ok;
    logic            clr_en;

    assign set_ok = set_en && (set_rd != '0);
    // A completion only counts if the register is actually pending; this
    // drops write-backs of ops that were in flight across a reset.
    assign clr_en = clr_req && (clr_rd != '0) && pending_q[clr_rd];

    assign pending_d[0] = 1'b0;

    // Set wins over clear so a same-register set+clear leaves the bit set.
    for (genvar gi = 1; gi < NREG; gi++) begin : g_pend
        logic set_hit;
        logic clr_hit;
        assign set_hit      = set_ok && (set_rd == AW'(gi));
        assign clr_hit      = clr_en && (clr_rd == AW'(gi));
        assign pending_d[gi] = set_hit || (pending_q[gi] && !clr_hit);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (set_ok && !clr_en) begin
            if (cnt_q != CW'(MAX_OUT)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!set_ok && clr_en) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending = rst ? '0 : pending_q;
    assign sb_cnt  = rst ? '0 : cnt_q;
    assign sb_full = !rst && (cnt_q == CW'(MAX_OUT));

endmodule

// File: rtl/hazard_ctrl_sb.sv
// hazard_ctrl_sb: hazard/forwarding controller with long-op scoreboard.
//   clk, rst                     clock, synchronous active-high reset
//   rs_d, rd_d, lng_d            decode sources (slot i at [i*AW +: AW]), dest, long op
//   rs_e, rd_e                   EX sources and destination
//   rd_m, rd_w                   M/W destinations
//   rslt_src_e, rslt_src_m       result-source codes in E/M
//   reg_wrt_m, reg_wrt_w         M/W regfile write enables
//   pc_src_e                     taken branch/jump in EX
//   busy                         memory not ready, freeze E/M
//   lng_issue_e                  EX instr handed to the long unit
//   lng_done, lng_rd             long unit write-back and its destination
//   stallf/stalld/stalle/stallm  stage hold enables
//   flushd/flushe                bubble insert in D/E
//   fwd_e                        per-operand forward select, 2 bits per slot
//   sb_cnt, sb_full              outstanding long ops, scoreboard full
module hazard_ctrl_sb
    import hazard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int NSRC    = 2,
    parameter int MAX_OUT = 4,
    localparam int AW     = $clog2(NREG),
    localparam int CW     = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSRC*AW-1:0] rs_d,
    input  logic [AW-1:0]    rd_d,
    input  logic             lng_d,
    input  logic [NSRC*AW-1:0] rs_e,
    input  logic [AW-1:0]    rd_e,
    input  logic [AW-1:0]    rd_m,
    input  logic [AW-1:0]    rd_w,
    input  logic [1:0]       rslt_src_e,
    input  logic [1:0]       rslt_src_m,
    input  logic             reg_wrt_m,
    input  logic             reg_wrt_w,
    input  logic             pc_src_e,
    input  logic             busy,
    input  logic             lng_issue_e,
    input  logic             lng_done,
    input  logic [AW-1:0]    lng_rd,
    output logic             stallf,
    output logic             stalld,
    output logic             stalle,
    output logic             stallm,
    output logic             flushd,
    output logic             flushe,
    output logic [NSRC*2-1:0] fwd_e,
    output logic [CW-1:0]    sb_cnt,
    output logic             sb_full
);

    logic [NREG-1:0] pending;
    logic [NSRC-1:0] lw_hit;
    logic [NSRC-1:0] raw_hit;
    logic            lwstall;
    logic            sbstall;
    logic            waw_hit;
    logic            issue_acc;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        logic [AW-1:0] rse;
        logic [AW-1:0] rsd;
        fwd_sel_t      sel;

        assign rse = rs_e[gi*AW +: AW];
        assign rsd = rs_d[gi*AW +: AW];

        // x0 is never forwarded; M is younger than W so it takes priority.
        always_comb begin
            sel = FWD_RF;
            if (rse != '0) begin
                if (reg_wrt_m && (rd_m == rse)) begin
                    sel = (rslt_src_m == RS_ALT) ? FWD_M_ALT : FWD_M;
                end else if (reg_wrt_w && (rd_w == rse)) begin
                    sel = FWD_W;
                end
            end
        end

        assign fwd_e[gi*2 +: 2] = sel;
        assign lw_hit[gi]       = (rsd != '0) && (rsd == rd_e);
        assign raw_hit[gi]      = (rsd != '0) && pending[rsd];
    end

    assign waw_hit = (rd_d != '0) && pending[rd_d];
    assign lwstall = (rslt_src_e == RS_LOAD) && (rd_e != '0) && (|lw_hit);
    assign sbstall = (|raw_hit) || waw_hit || (lng_d && sb_full);

    assign stallf = lwstall || sbstall || busy;
    assign stalld = stallf;
    assign stalle = busy;
    assign stallm = busy;
    assign flushe = (lwstall || sbstall || pc_src_e) && !busy;
    assign flushd = pc_src_e && !busy;

    // A frozen EX stage does not hand its op to the unit; flushes do not
    // cancel an accepted issue since the op has already left EX.
    assign issue_acc = lng_issue_e && !busy && (rd_e != '0);

    hazard_sb_regs #(
        .NREG    (NREG),
        .MAX_OUT (MAX_OUT)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue_acc),
        .set_rd  (rd_e),
        .clr_req (lng_done),
        .clr_rd  (lng_rd),
        .pending (pending),
        .sb_cnt  (sb_cnt),
        .sb_full (sb_full)
    );

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
module tb_hazard_ctrl_sb;

    localparam int NREG    = 32;
    localparam int NSRC    = 2;
    localparam int MAX_OUT = 4;
    localparam int AW      = 5;
    localparam int CW      = 3;

    typedef struct {
        logic             rst;
        logic [NSRC*AW-1:0] rs_d;
        logic [AW-1:0]    rd_d;
        logic             lng_d;
        logic [NSRC*AW-1:0] rs_e;
        logic [AW-1:0]    rd_e;
        logic [AW-1:0]    rd_m;
        logic [AW-1:0]    rd_w;
        logic [1:0]       rslt_src_e;
        logic [1:0]       rslt_src_m;
        logic             reg_wrt_m;
        logic             reg_wrt_w;
        logic             pc_src_e;
        logic             busy;
        logic             lng_issue_e;
        logic             lng_done;
        logic [AW-1:0]    lng_rd;
    } stim_t;

    typedef struct {
        string            tag;
        logic             sf, sd, se, sm, fd, fe;
        logic [NSRC*2-1:0] fwd;
        logic [CW-1:0]    cnt;
        logic             full;
    } exp_t;

    logic clk;
    logic rst;
    logic [NSRC*AW-1:0] rs_d, rs_e;
    logic [AW-1:0] rd_d, rd_e, rd_m, rd_w, lng_rd;
    logic lng_d, reg_wrt_m, reg_wrt_w, pc_src_e, busy, lng_issue_e, lng_done;
    logic [1:0] rslt_src_e, rslt_src_m;
    logic stallf, stalld, stalle, stallm, flushd, flushe, sb_full;
    logic [NSRC*2-1:0] fwd_e;
    logic [CW-1:0] sb_cnt;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;
    exp_t exp_q[$];

    // Reference state: which registers await a long-op result, and how many.
    bit pend_m [NREG];
    int cnt_m = 0;

    hazard_ctrl_sb #(.NREG(NREG), .NSRC(NSRC), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rd_d(rd_d), .lng_d(lng_d),
        .rs_e(rs_e), .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .rslt_src_e(rslt_src_e), .rslt_src_m(rslt_src_m),
        .reg_wrt_m(reg_wrt_m), .reg_wrt_w(reg_wrt_w), .pc_src_e(pc_src_e),
        .busy(busy), .lng_issue_e(lng_issue_e), .lng_done(lng_done),
        .lng_rd(lng_rd), .stallf(stallf), .stalld(stalld), .stalle(stalle),
        .stallm(stallm), .flushd(flushd), .flushe(flushe), .fwd_e(fwd_e),
        .sb_cnt(sb_cnt), .sb_full(sb_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.rs_d = '0; s.rd_d = '0; s.lng_d = 0; s.rs_e = '0;
        s.rd_e = '0; s.rd_m = '0; s.rd_w = '0; s.rslt_src_e = 2'b00;
        s.rslt_src_m = 2'b00; s.reg_wrt_m = 0; s.reg_wrt_w = 0;
        s.pc_src_e = 0; s.busy = 0; s.lng_issue_e = 0; s.lng_done = 0;
        s.lng_rd = '0;
        return s;
    endfunction

    function automatic bit is_pend(input stim_t s, input int r);
        if (s.rst || r == 0) return 0;
        return pend_m[r];
    endfunction

    function automatic exp_t model_eval(input stim_t s, input string tag);
        exp_t e;
        bit lw = 0, sb = 0;
        int cnt_eff;
        e.tag = tag;
        e.fwd = '0;
        for (int i = 0; i < NSRC; i++) begin
            int rd_src = int'(s.rs_d[i*AW +: AW]);
            int re_src = int'(s.rs_e[i*AW +: AW]);
            int code = 0;
            if (rd_src != 0 && rd_src == int'(s.rd_e)) lw = 1;
            if (is_pend(s, rd_src)) sb = 1;
            if (re_src != 0) begin
                if (s.reg_wrt_m && int'(s.rd_m) == re_src) code = (s.rslt_src_m == 2'b11) ? 3 : 2;
                else if (s.reg_wrt_w && int'(s.rd_w) == re_src) code = 1;
            end
            e.fwd[i*2 +: 2] = 2'(code);
        end
        lw = lw && (s.rslt_src_e == 2'b01) && (s.rd_e != 0);
        cnt_eff = s.rst ? 0 : cnt_m;
        e.full = (cnt_eff == MAX_OUT);
        e.cnt  = CW'(cnt_eff);
        if (is_pend(s, int'(s.rd_d))) sb = 1;
        if (s.lng_d && e.full) sb = 1;
        e.sf = lw || sb || s.busy;
        e.sd = e.sf;
        e.se = s.busy;
        e.sm = s.busy;
        e.fe = (lw || sb || s.pc_src_e) && !s.busy;
        e.fd = s.pc_src_e && !s.busy;
        return e;
    endfunction

    task automatic model_step(input stim_t s);
        bit acc, clr;
        if (s.rst) begin
            for (int r = 0; r < NREG; r++) pend_m[r] = 0;
            cnt_m = 0;
        end else begin
            acc = s.lng_issue_e && !s.busy && (s.rd_e != 0);
            clr = s.lng_done && (s.lng_rd != 0) && pend_m[s.lng_rd];
            if (clr) pend_m[s.lng_rd] = 0;
            if (acc) pend_m[s.rd_e] = 1;
            cnt_m = cnt_m + int'(acc) - int'(clr);
            if (cnt_m > MAX_OUT) cnt_m = MAX_OUT;
            if (cnt_m < 0) cnt_m = 0;
        end
    endtask

    task automatic run(input stim_t s, input string tag);
        @(posedge clk);
        #1;
        rst = s.rst; rs_d = s.rs_d; rd_d = s.rd_d; lng_d = s.lng_d;
        rs_e = s.rs_e; rd_e = s.rd_e; rd_m = s.rd_m; rd_w = s.rd_w;
        rslt_src_e = s.rslt_src_e; rslt_src_m = s.rslt_src_m;
        reg_wrt_m = s.reg_wrt_m; reg_wrt_w = s.reg_wrt_w;
        pc_src_e = s.pc_src_e; busy = s.busy; lng_issue_e = s.lng_issue_e;
        lng_done = s.lng_done; lng_rd = s.lng_rd;
        exp_q.push_back(model_eval(s, tag));
        model_step(s);
    endtask

    task automatic chk(input string tag, input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%0h exp=%0h", tag, name, act, exp);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d %s: stall=%b%b%b%b flush=%b%b fwd=%b cnt=%0d full=%b",
                         txn, e.tag, stallf, stalld, stalle, stallm, flushd, flushe,
                         fwd_e, sb_cnt, sb_full);
                chk(e.tag, "stallf", 8'(stallf), 8'(e.sf));
                chk(e.tag, "stalld", 8'(stalld), 8'(e.sd));
                chk(e.tag, "stalle", 8'(stalle), 8'(e.se));
                chk(e.tag, "stallm", 8'(stallm), 8'(e.sm));
                chk(e.tag, "flushd", 8'(flushd), 8'(e.fd));
                chk(e.tag, "flushe", 8'(flushe), 8'(e.fe));
                chk(e.tag, "fwd_e", 8'(fwd_e), 8'(e.fwd));
                chk(e.tag, "sb_cnt", 8'(sb_cnt), 8'(e.cnt));
                chk(e.tag, "sb_full", 8'(sb_full), 8'(e.full));
            end
        end
    end

    function automatic logic [AW-1:0] rnd_reg();
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        stim_t s;
        for (int r = 0; r < NREG; r++) pend_m[r] = 0;
        s = idle();
        s.rst = 1;
        rst = 1; rs_d = '0; rd_d = '0; lng_d = 0; rs_e = '0; rd_e = '0;
        rd_m = '0; rd_w = '0; rslt_src_e = '0; rslt_src_m = '0; reg_wrt_m = 0;
        reg_wrt_w = 0; pc_src_e = 0; busy = 0; lng_issue_e = 0; lng_done = 0;
        lng_rd = '0;
        run(s, "reset");
        run(s, "reset");

        // Forwarding: M beats W, alternate result code from M.
        s = idle();
        s.rs_e = {5'd5, 5'd5}; s.rd_m = 5'd5; s.rd_w = 5'd5;
        s.reg_wrt_m = 1; s.reg_wrt_w = 1;
        run(s, "fwd_m");
        s.rslt_src_m = 2'b11;
        run(s, "fwd_m_alt");
        s.reg_wrt_m = 0;
        run(s, "fwd_w");
        s.rs_e = {5'd0, 5'd5}; s.rd_w = 5'd0;
        run(s, "fwd_x0");

        // Load-use stall and the rd_e==0 exemption.
        s = idle();
        s.rslt_src_e = 2'b01; s.rd_e = 5'd7; s.rs_d = {5'd7, 5'd0};
        run(s, "lwstall");
        s.rd_e = 5'd0;
        run(s, "lw_rd0");

        // Long op to x9: RAW stall until the cycle after completion.
        s = idle();
        s.lng_issue_e = 1; s.rd_e = 5'd9;
        run(s, "issue_x9");
        s = idle();
        s.rs_d = {5'd0, 5'd9};
        repeat (3) run(s, "raw_x9");
        s.lng_done = 1; s.lng_rd = 5'd9;
        run(s, "done_x9");
        s.lng_done = 0;
        run(s, "released_x9");

        // Fill to MAX_OUT, full stalls a long op, then swap one.
        for (int r = 1; r <= 4; r++) begin
            s = idle();
            s.lng_issue_e = 1; s.rd_e = AW'(r);
            run(s, "fill");
        end
        s = idle();
        s.lng_d = 1; s.rd_d = 5'd20;
        run(s, "full_lng_d");
        s = idle();
        s.lng_issue_e = 1; s.rd_e = 5'd6; s.lng_done = 1; s.lng_rd = 5'd1;
        run(s, "swap");
        s = idle();
        s.rs_d = {5'd6, 5'd1}; s.rd_d = 5'd6;
        run(s, "after_swap");

        // Memory busy freezes everything and blocks issue.
        s = idle();
        s.busy = 1; s.pc_src_e = 1; s.lng_issue_e = 1; s.rd_e = 5'd10;
        run(s, "busy");
        s.busy = 0; s.lng_issue_e = 0;
        run(s, "busy_drop");
        s = idle();
        s.rs_d = {5'd0, 5'd10};
        run(s, "x10_free");

        // Drain, then an op in flight across reset.
        for (int r = 2; r <= 6; r++) begin
            s = idle();
            s.lng_done = 1; s.lng_rd = AW'(r);
            run(s, "drain");
        end
        s = idle();
        s.lng_issue_e = 1; s.rd_e = 5'd3;
        run(s, "issue_x3");
        s = idle();
        s.rst = 1; s.rs_d = {5'd0, 5'd3};
        run(s, "rst_inflight");
        s = idle();
        s.lng_done = 1; s.lng_rd = 5'd3;
        run(s, "stale_done");
        s = idle();
        s.rs_d = {5'd3, 5'd0};
        run(s, "post_stale");

        // Randomised traffic over a small register window to force hits.
        for (int n = 0; n < 1500; n++) begin
            s = idle();
            s.rst         = ($urandom_range(0, 99) == 0);
            s.rs_d        = {rnd_reg(), rnd_reg()};
            s.rd_d        = rnd_reg();
            s.lng_d       = ($urandom_range(0, 3) == 0);
            s.rs_e        = {rnd_reg(), rnd_reg()};
            s.rd_e        = rnd_reg();
            s.rd_m        = rnd_reg();
            s.rd_w        = rnd_reg();
            s.rslt_src_e  = 2'($urandom_range(0, 3));
            s.rslt_src_m  = 2'($urandom_range(0, 3));
            s.reg_wrt_m   = 1'($urandom_range(0, 1));
            s.reg_wrt_w   = 1'($urandom_range(0, 1));
            s.pc_src_e    = ($urandom_range(0, 7) == 0);
            s.busy        = ($urandom_range(0, 5) == 0);
            s.lng_issue_e = ($urandom_range(0, 2) == 0);
            s.lng_done    = ($urandom_range(0, 2) == 0);
            s.lng_rd      = rnd_reg();
            run(s, "rand");
        end

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0 pending expectations", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
